// File: rtl/count_stim_pkg.sv
// count_stim_pkg: shared definitions for the count-enable stimulus generator.
//   - stim_state_e : run FSM states
//   - MIN_STABLE_DEF : shortest high/low time the downstream synchronizer
//                      plus debouncer reliably passes
//   - clamp_min    : raises a requested duration to a floor value
package count_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_FIN  = 2'd3
  } stim_state_e;

  // Downstream path: 5 cycles of synchronizer latency, a 16-cycle debounce
  // span, and 3 cycles of margin.
  localparam int SYNC_STAGES    = 5;
  localparam int DEBOUNCE_SPAN  = 16;
  localparam int STABLE_MARGIN  = 3;
  localparam int MIN_STABLE_DEF = SYNC_STAGES + DEBOUNCE_SPAN + STABLE_MARGIN;

  function automatic logic [31:0] clamp_min(input logic [31:0] v, input logic [31:0] lo);
    return (v < lo) ? lo : v;
  endfunction

endpackage

// File: rtl/stim_timer.sv
// stim_timer: loadable down-counter with a zero flag.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (has priority over dec)
//   dec       : decrement by one, saturating at zero
//   load_val  : value to load
//   zero      : counter currently equals zero
// A phase of L cycles is timed by loading L-1; zero is seen in the last cycle.
module stim_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/count_en_stim.sv
// count_en_stim: emits a programmable number of clean enable windows so a
// debounced downstream counter advances by a known amount.
//   clk, rst     : clock, synchronous active-high reset
//   start        : one-cycle run request, honoured only in IDLE
//   abort        : terminates a run in progress; beats start in IDLE
//   num_windows  : windows to emit (latched on start)
//   on_cycles    : high time per window (latched, clamped to MIN_STABLE)
//   off_cycles   : low time after each window (latched, clamped to MIN_STABLE)
//   en_out       : registered enable drive
//   busy         : run in progress
//   done         : one-cycle pulse on normal completion
//   aborted      : one-cycle pulse after an abort
//   window_idx   : zero-based index of the current window
module count_en_stim
  import count_stim_pkg::*;
#(
  parameter int MIN_STABLE = MIN_STABLE_DEF,
  parameter int LEN_W      = 16,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_windows,
  input  logic [LEN_W-1:0] on_cycles,
  input  logic [LEN_W-1:0] off_cycles,
  output logic             en_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] window_idx
);

  stim_state_e      state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [LEN_W-1:0] lon_q, lon_d;
  logic [LEN_W-1:0] loff_q, loff_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             en_q, busy_q, done_q, aborted_q;
  logic             abort_evt;

  logic             tmr_load, tmr_dec, tmr_zero;
  logic [LEN_W-1:0] tmr_val;
  logic [LEN_W-1:0] lon_new, loff_new;

  assign lon_new  = LEN_W'(clamp_min(32'(on_cycles),  32'(MIN_STABLE)));
  assign loff_new = LEN_W'(clamp_min(32'(off_cycles), 32'(MIN_STABLE)));

  stim_timer #(.W(LEN_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    lon_d     = lon_q;
    loff_d    = loff_q;
    idx_d     = idx_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_val   = lon_q - LEN_W'(1);
    abort_evt = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // abort in IDLE has no visible effect except to drop a coincident start
        if (start && !abort) begin
          num_d  = num_windows;
          lon_d  = lon_new;
          loff_d = loff_new;
          idx_d  = '0;
          if (num_windows == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d  = ST_ON;
            tmr_load = 1'b1;
            tmr_val  = lon_new - LEN_W'(1);
          end
        end
      end

      ST_ON: begin
        if (abort) begin
          state_d   = ST_IDLE;
          idx_d     = '0;
          abort_evt = 1'b1;
        end else if (tmr_zero) begin
          state_d  = ST_OFF;
          tmr_load = 1'b1;
          tmr_val  = loff_q - LEN_W'(1);
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_OFF: begin
        if (abort) begin
          state_d   = ST_IDLE;
          idx_d     = '0;
          abort_evt = 1'b1;
        end else if (tmr_zero) begin
          if (idx_q == (num_q - CNT_W'(1))) begin
            state_d = ST_FIN;
            idx_d   = '0;
          end else begin
            state_d  = ST_ON;
            idx_d    = idx_q + CNT_W'(1);
            tmr_load = 1'b1;
            tmr_val  = lon_q - LEN_W'(1);
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so en_out is a plain
  // flop output with no combinational path from any input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      num_q     <= '0;
      lon_q     <= '0;
      loff_q    <= '0;
      idx_q     <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      lon_q     <= lon_d;
      loff_q    <= loff_d;
      idx_q     <= idx_d;
      en_q      <= (state_d == ST_ON);
      busy_q    <= (state_d == ST_ON) || (state_d == ST_OFF);
      done_q    <= (state_d == ST_FIN);
      aborted_q <= abort_evt;
    end
  end

  assign en_out     = en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign window_idx = idx_q;

endmodule

// File: tb/tb_count_en_stim.sv
module tb_count_en_stim;

  localparam int LEN_W  = 16;
  localparam int CNT_W  = 8;
  localparam int MIN_ST = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_windows;
  logic [LEN_W-1:0] on_cycles;
  logic [LEN_W-1:0] off_cycles;
  logic             en_out, busy, done, aborted;
  logic [CNT_W-1:0] window_idx;

  int checks   = 0;
  int failures = 0;

  count_en_stim dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .num_windows (num_windows),
    .on_cycles   (on_cycles),
    .off_cycles  (off_cycles),
    .en_out      (en_out),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .window_idx  (window_idx)
  );

  always #5 clk = ~clk;

  // Downstream harness: 4-stage synchronizer, 16-cycle debouncer, 16-bit
  // counter advancing on every debounced-high cycle.
  logic [3:0]  sync_r;
  logic        deb_r;
  int          deb_cnt;
  logic [15:0] ctr;
  bit          ctr_clr = 1'b0;

  always @(posedge clk) begin
    if (rst || ctr_clr) begin
      sync_r  <= '0;
      deb_r   <= 1'b0;
      deb_cnt <= 0;
      ctr     <= '0;
    end else begin
      sync_r <= {sync_r[2:0], en_out};
      if (sync_r[3] != deb_r) begin
        if (deb_cnt == 15) begin
          deb_r   <= sync_r[3];
          deb_cnt <= 0;
        end else begin
          deb_cnt <= deb_cnt + 1;
        end
      end else begin
        deb_cnt <= 0;
      end
      if (deb_r) ctr <= ctr + 16'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [11:0] obs_vec();
    return {en_out, busy, done, aborted, window_idx};
  endfunction

  // Expected {en,busy,done,aborted,idx} k cycles after the start edge,
  // derived from the window timeline: each window is lon high then loff low.
  function automatic logic [11:0] model(input int n, input int lon, input int loff, input int k);
    int p, w, r;
    if (n == 0) return (k == 1) ? 12'h200 : 12'h000;
    p = lon + loff;
    if (k >= 1 && k <= n * p) begin
      w = (k - 1) / p;
      r = (k - 1) % p;
      return {(r < lon), 1'b1, 1'b0, 1'b0, 8'(w)};
    end
    if (k == n * p + 1) return 12'h200;
    return 12'h000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    num_windows = CNT_W'($urandom);
    on_cycles   = LEN_W'($urandom);
    off_cycles  = LEN_W'($urandom);
  endtask

  // One transaction: start a run and follow it cycle by cycle.
  // abort_at/restart_at are cycle offsets (0 = none) at which abort/start
  // are presented; per_cycle selects full-vector checks or summary totals.
  task automatic run(input string name, input int n, input int on, input int off,
                     input int abort_at, input int restart_at, input bit per_cycle);
    int lon, loff, p, total, last;
    int en_cnt, busy_cnt, done_at, done_cnt, max_idx;
    logic [11:0] obs, exp;
    lon   = (on  < MIN_ST) ? MIN_ST : on;
    loff  = (off < MIN_ST) ? MIN_ST : off;
    p     = lon + loff;
    total = (n == 0) ? 1 : n * p + 1;
    last  = (abort_at > 0) ? abort_at + 1 : total;
    en_cnt = 0; busy_cnt = 0; done_at = 0; done_cnt = 0; max_idx = 0;

    num_windows = CNT_W'(n);
    on_cycles   = LEN_W'(on);
    off_cycles  = LEN_W'(off);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= last + 3; k++) begin
      obs = obs_vec();
      if (abort_at > 0 && k == abort_at + 1)     exp = 12'h100;
      else if (abort_at > 0 && k > abort_at + 1) exp = 12'h000;
      else                                       exp = model(n, lon, loff, k);
      if (per_cycle) begin
        check($sformatf("%s@%0d", name, k), 64'(obs), 64'(exp));
      end else begin
        en_cnt   += int'(en_out);
        busy_cnt += int'(busy);
        if (done) begin
          done_cnt++;
          if (done_at == 0) done_at = k;
        end
        if (int'(window_idx) > max_idx) max_idx = int'(window_idx);
      end
      abort = (k == abort_at);
      start = (k == restart_at);
      scramble_inputs();
      step();
    end
    abort = 1'b0;
    start = 1'b0;
    if (!per_cycle) begin
      check({name, "_en_cycles"},   64'(en_cnt),   64'(n * lon));
      check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(n * p));
      check({name, "_done_at"},     64'(done_at),  64'(total));
      check({name, "_done_cnt"},    64'(done_cnt), 64'd1);
      check({name, "_max_idx"},     64'(max_idx),  64'((n > 0) ? n - 1 : 0));
    end
    $display("run %s: N=%0d on=%0d off=%0d abort_at=%0d restart_at=%0d checks=%0d failures=%0d",
             name, n, on, off, abort_at, restart_at, checks, failures);
  endtask

  initial begin
    int n, on, off, ab, rs, p;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    num_windows = '0; on_cycles = '0; off_cycles = '0;
    repeat (3) step();
    check("reset_outputs", 64'(obs_vec()), 64'd0);
    rst = 1'b0;
    step();
    check("idle_outputs", 64'(obs_vec()), 64'd0);

    // Basic timeline: en t+1..30, t+71..100, t+141..170; done at t+211.
    run("basic", 3, 30, 40, 0, 0, 1'b1);
    // Clamp: 24 high, 24 low, done.
    run("clamp", 1, 5, 0, 0, 0, 1'b1);
    run("zero", 0, 30, 30, 0, 0, 1'b1);
    // Abort during the ON phase of window 2 (offsets 121..150).
    run("abort_w2", 4, 30, 30, 130, 0, 1'b1);
    // start while busy must not disturb timing.
    run("restart_busy", 2, 25, 26, 0, 40, 1'b1);

    // start and abort together in IDLE: abort wins, nothing happens.
    num_windows = 8'd2; on_cycles = 16'd30; off_cycles = 16'd30;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 64'(obs_vec()), 64'd0);
    step();
    check("start_abort_idle2", 64'(obs_vec()), 64'd0);
    $display("run start_abort_idle: checks=%0d failures=%0d", checks, failures);

    // Reset in the middle of an ON phase.
    num_windows = 8'd2; on_cycles = 16'd30; off_cycles = 16'd30;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    check("pre_reset_on", 64'(obs_vec()), 64'(model(2, 30, 30, 10)));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_on_reset", 64'(obs_vec()), 64'd0);
    $display("run mid_reset: checks=%0d failures=%0d", checks, failures);
    run("after_reset", 2, 24, 30, 0, 0, 1'b1);

    // Randomized runs, some with an abort.
    for (int i = 0; i < 8; i++) begin
      n   = int'($urandom_range(0, 4));
      on  = int'($urandom_range(0, 45));
      off = int'($urandom_range(0, 45));
      p   = ((on < MIN_ST) ? MIN_ST : on) + ((off < MIN_ST) ? MIN_ST : off);
      ab  = 0;
      rs  = 0;
      if (n > 0) begin
        if (i % 3 == 2) ab = int'($urandom_range(1, n * p));
        else            rs = int'($urandom_range(1, n * p));
      end
      run($sformatf("rand%0d", i), n, on, off, ab, rs, 1'b1);
    end

    // Downstream counter advances by on_cycles per window.
    ctr_clr = 1'b1;
    step();
    ctr_clr = 1'b0;
    run("downstream", 5, 100, 50, 0, 0, 1'b0);
    repeat (30) step();
    check("downstream_count", 64'(ctr), 64'd500);

    // Extremes.
    run("n255", 255, 24, 24, 0, 0, 1'b0);
    run("on_max", 1, 65535, 0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
